// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} sa_state_t;

   // Counter must hold WIDTH itself so it never wraps inside an operation.
   function automatic int cntWidth(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/serial_adder_ctrl_fullAdder.sv
// Single-bit full adder cell reused every cycle by the serial controller.
module fullAdder (
   input  logic A,
   input  logic B,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = A ^ B ^ cin;
   assign cout = (A & B) | (cin & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full adder, LSB first, start/busy/done handshake.
module serial_adder_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = cntWidth(WIDTH);

   sa_state_t        stateQ, stateD;
   logic [WIDTH-1:0] saQ, saD;
   logic [WIDTH-1:0] sbQ, sbD;
   logic [WIDTH-1:0] accQ, accD;
   logic [WIDTH-1:0] sumQ, sumD;
   logic [CW-1:0]    cntQ, cntD;
   logic             cQ, cD;
   logic             coutQ, coutD;
   logic             busyQ, doneQ;
   logic             faSum, faCout;
   logic [WIDTH-1:0] accShift;

   fullAdder uFullAdder (
      .A    (saQ[0]),
      .B    (sbQ[0]),
      .cin  (cQ),
      .sum  (faSum),
      .cout (faCout)
   );

   // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
   always_comb begin
      accShift            = accQ >> 1;
      accShift[WIDTH-1]   = faSum;
   end

   always_comb begin
      stateD = stateQ;
      saD    = saQ;
      sbD    = sbQ;
      accD   = accQ;
      cD     = cQ;
      cntD   = cntQ;
      sumD   = sumQ;
      coutD  = coutQ;
      case (stateQ)
         S_IDLE, S_DONE: begin
            if (start) begin
               saD    = a;
               sbD    = b;
               cD     = cin;
               cntD   = '0;
               stateD = S_RUN;
            end else begin
               stateD = S_IDLE;
            end
         end
         S_RUN: begin
            saD  = saQ >> 1;
            sbD  = sbQ >> 1;
            accD = accShift;
            cD   = faCout;
            cntD = cntQ + CW'(1);
            if (cntQ == CW'(WIDTH - 1)) begin
               sumD   = accShift;
               coutD  = faCout;
               stateD = S_DONE;
            end
         end
         default: stateD = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stateQ <= S_IDLE;
         saQ    <= '0;
         sbQ    <= '0;
         accQ   <= '0;
         cQ     <= 1'b0;
         cntQ   <= '0;
         sumQ   <= '0;
         coutQ  <= 1'b0;
         busyQ  <= 1'b0;
         doneQ  <= 1'b0;
      end else begin
         stateQ <= stateD;
         saQ    <= saD;
         sbQ    <= sbD;
         accQ   <= accD;
         cQ     <= cD;
         cntQ   <= cntD;
         sumQ   <= sumD;
         coutQ  <= coutD;
         busyQ  <= (stateD == S_RUN);
         doneQ  <= (stateD == S_DONE);
      end
   end

   assign busy = busyQ;
   assign done = doneQ;
   assign sum  = sumQ;
   assign cout = coutQ;

endmodule
